aes_trace_sequencer: RTL

//  Synthesizable, parametrised stimulus sequencer for AES_top trace campaigns (power/VCD capture).

---
 rtl/aes_tb_pkg.sv | 9 +
 rtl/aes_lfsr128.sv | 21 ++
 rtl/aes_trace_sequencer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/aes_tb_pkg.sv
// aes_tb_pkg: shared types and constants for the AES trace sequencer
package aes_tb_pkg;
  localparam int DATA_W = 128;
  localparam logic [DATA_W-1:0] LFSR_POLY = 128'h87;
  localparam logic [1:0] MODE_FIXED  = 2'd0;
  localparam logic [1:0] MODE_RANDOM = 2'd1;
  localparam logic [1:0] MODE_TVLA   = 2'd2;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_GAP, S_DONE, S_ERR} state_t;
endpackage

// File: rtl/aes_lfsr128.sv
// aes_lfsr128: left-shifting Galois LFSR with step enable
//  clk/rst : clock, async active-high reset (loads SEED)
//  en      : advance one step
//  nxt     : value the register takes on the next step
import aes_tb_pkg::*;
module aes_lfsr128 #(
  parameter int W = DATA_W,
  parameter logic [W-1:0] SEED = W'(1),
  parameter logic [W-1:0] POLY = LFSR_POLY
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] nxt
);
  logic [W-1:0] q;
  assign nxt = {q[W-2:0], 1'b0} ^ (q[W-1] ? POLY : '0);
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= SEED;
    else if (en) q <= nxt;
endmodule

// File: rtl/aes_trace_sequencer.sv
// aes_trace_sequencer: issues back-to-back AES encryptions for trace capture
//  AES_clk/AES_rst          : clock, async active-high reset
//  start/abort              : campaign launch / cancel pulses
//  mode/num_traces/fixed_pt/key : campaign setup, sampled on start
//  aes_en/aes_data_in/aes_key_in : drive AES_top
//  aes_data_out/aes_data_out_valid : AES_top result
//  trig/trace_cls/trace_idx : per-trace capture trigger and tagging
//  ct_out/ct_valid          : captured ciphertext
//  busy/done/err            : status (done/err sticky)
import aes_tb_pkg::*;
module aes_trace_sequencer #(
  parameter int CNT_W = 16,
  parameter int EN_HOLD = 51,
  parameter int GAP = 15,
  parameter int TMO = 255,
  parameter logic [DATA_W-1:0] SEED = 128'h1
) (
  input  logic              AES_clk,
  input  logic              AES_rst,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        mode,
  input  logic [CNT_W-1:0]  num_traces,
  input  logic [DATA_W-1:0] fixed_pt,
  input  logic [DATA_W-1:0] key,
  output logic              aes_en,
  output logic [DATA_W-1:0] aes_data_in,
  output logic [DATA_W-1:0] aes_key_in,
  input  logic [DATA_W-1:0] aes_data_out,
  input  logic              aes_data_out_valid,
  output logic              trig,
  output logic              trace_cls,
  output logic [CNT_W-1:0]  trace_idx,
  output logic [DATA_W-1:0] ct_out,
  output logic              ct_valid,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int MX = EN_HOLD > TMO ? (EN_HOLD > GAP ? EN_HOLD : GAP) : (TMO > GAP ? TMO : GAP);
  localparam int CW = $clog2(MX + 1);
  state_t state;
  logic [1:0] mode_q;
  logic [CNT_W-1:0] num_q;
  logic [DATA_W-1:0] pt_q, rnd_val;
  logic [CW-1:0] cnt;
  logic got, rnd, hold_ok, timeout, last;
  assign rnd = mode_q == MODE_RANDOM || (mode_q == MODE_TVLA && trace_idx[0]);
  // one counter serves as both hold and timeout counter: both start at RUN entry
  assign hold_ok = cnt >= CW'(EN_HOLD - 1);
  assign timeout = cnt == CW'(TMO - 1);
  assign last = trace_idx == num_q - 1'b1;
  aes_lfsr128 #(.W(DATA_W), .SEED(SEED), .POLY(LFSR_POLY)) u_lfsr (
    .clk(AES_clk), .rst(AES_rst), .en(state == S_LOAD && rnd && !abort), .nxt(rnd_val)
  );
  always_ff @(posedge AES_clk or posedge AES_rst) begin
    if (AES_rst) begin
      state <= S_IDLE;
      mode_q <= '0;
      num_q <= '0;
      pt_q <= '0;
      cnt <= '0;
      got <= 1'b0;
      aes_en <= 1'b0;
      aes_data_in <= '0;
      aes_key_in <= '0;
      trig <= 1'b0;
      trace_cls <= 1'b0;
      trace_idx <= '0;
      ct_out <= '0;
      ct_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      trig <= 1'b0;
      ct_valid <= 1'b0;
      if (abort) begin
        state <= S_IDLE;
        aes_en <= 1'b0;
        busy <= 1'b0;
        done <= 1'b0;
        err <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_DONE, S_ERR: if (start) begin
            mode_q <= mode == 2'd3 ? MODE_FIXED : mode;
            num_q <= num_traces;
            pt_q <= fixed_pt;
            aes_key_in <= key;
            trace_idx <= '0;
            err <= 1'b0;
            done <= num_traces == '0;
            busy <= num_traces != '0;
            state <= num_traces == '0 ? S_DONE : S_LOAD;
          end
          S_LOAD: begin
            aes_data_in <= rnd ? rnd_val : pt_q;
            trace_cls <= rnd;
            aes_en <= 1'b1;
            trig <= 1'b1;
            cnt <= '0;
            got <= 1'b0;
            state <= S_RUN;
          end
          S_RUN: begin
            cnt <= cnt + 1'b1;
            if (aes_data_out_valid && !got) begin
              ct_out <= aes_data_out;
              ct_valid <= 1'b1;
              got <= 1'b1;
            end
            if (hold_ok && (got || aes_data_out_valid)) begin
              aes_en <= 1'b0;
              cnt <= '0;
              state <= S_GAP;
            end else if (timeout && !got && !aes_data_out_valid) begin
              aes_en <= 1'b0;
              busy <= 1'b0;
              err <= 1'b1;
              state <= S_ERR;
            end
          end
          S_GAP: begin
            cnt <= cnt + 1'b1;
            // GAP-1 cycles here plus the LOAD cycle keep aes_en low for exactly GAP cycles
            if (cnt == CW'(GAP - 2)) begin
              trace_idx <= last ? trace_idx : trace_idx + 1'b1;
              busy <= !last;
              done <= last;
              state <= last ? S_DONE : S_LOAD;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule
